// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller and the EX-stage forwarding unit.
// State encoding, forward-select constants and the x0-aware register match.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // x0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flush, memory-wait freeze
// and a free-running stall-cycle performance counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_ex_memRead,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_uses_rs2,
  input  logic             branch_taken,
  input  logic             ex_mem_memAccess,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [2:0] LU_INIT = 3'(LU_STALL_CYCLES - 1);

  state_t     state, state_n;
  state_t     ret_state, ret_state_n;
  state_t     eff_state;
  logic [2:0] lu_cnt, lu_cnt_n;
  logic       mem_wait;
  logic       lu_haz;

  assign mem_wait = ex_mem_memAccess & ~dmem_ready;
  assign lu_haz   = id_ex_memRead &
                    (reg_match(id_ex_rd, if_id_rs1) |
                     (if_id_uses_rs2 & reg_match(id_ex_rd, if_id_rs2)));

  // Leaving MEM_WAIT resumes the saved state and is evaluated in the same cycle.
  assign eff_state = (state == MEM_WAIT) ? ret_state : state;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    state_n      = eff_state;
    ret_state_n  = ret_state;
    lu_cnt_n     = lu_cnt;

    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_n      = RUN;
    end else if (mem_wait) begin
      // A pending branch stays in EX because EX/MEM is frozen; it is taken on release.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_freeze = 1'b1;
      state_n     = MEM_WAIT;
      ret_state_n = eff_state;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_n      = RUN;
      lu_cnt_n     = 3'd0;
    end else if (eff_state == LU_STALL) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (lu_cnt <= 3'd1) begin
        state_n  = RUN;
        lu_cnt_n = 3'd0;
      end else begin
        state_n  = LU_STALL;
        lu_cnt_n = lu_cnt - 3'd1;
      end
    end else if (lu_haz) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (LU_STALL_CYCLES > 1) begin
        state_n  = LU_STALL;
        lu_cnt_n = LU_INIT;
      end else begin
        state_n  = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state       <= RUN;
      ret_state   <= RUN;
      lu_cnt      <= 3'd0;
      stall_count <= '0;
    end else begin
      state     <= state_n;
      ret_state <= ret_state_n;
      lu_cnt    <= lu_cnt_n;
      if (!pc_write)
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with single-cycle bubbles,
// one with three-cycle bubbles, both driven by the same stimulus.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        id_ex_memRead;
  logic [4:0]  id_ex_rd;
  logic [4:0]  if_id_rs1;
  logic [4:0]  if_id_rs2;
  logic        if_id_uses_rs2;
  logic        branch_taken;
  logic        ex_mem_memAccess;
  logic        dmem_ready;

  logic        pc_write1, if_id_write1, if_id_flush1, id_ex_bubble1, pipe_freeze1;
  logic [31:0] stall_count1;
  logic        pc_write3, if_id_write3, if_id_flush3, id_ex_bubble3, pipe_freeze3;
  logic [31:0] stall_count3;

  int tests  = 0;
  int failed = 0;

  hazard_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .id_ex_memRead(id_ex_memRead), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_uses_rs2(if_id_uses_rs2),
    .branch_taken(branch_taken), .ex_mem_memAccess(ex_mem_memAccess), .dmem_ready(dmem_ready),
    .pc_write(pc_write1), .if_id_write(if_id_write1), .if_id_flush(if_id_flush1),
    .id_ex_bubble(id_ex_bubble1), .pipe_freeze(pipe_freeze1), .stall_count(stall_count1)
  );

  hazard_ctrl #(.LU_STALL_CYCLES(3), .CNT_W(32)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .id_ex_memRead(id_ex_memRead), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_uses_rs2(if_id_uses_rs2),
    .branch_taken(branch_taken), .ex_mem_memAccess(ex_mem_memAccess), .dmem_ready(dmem_ready),
    .pc_write(pc_write3), .if_id_write(if_id_write3), .if_id_flush(if_id_flush3),
    .id_ex_bubble(id_ex_bubble3), .pipe_freeze(pipe_freeze3), .stall_count(stall_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output vector order: pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze.
  task automatic check3(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, pc_write3, if_id_write3, if_id_flush3, id_ex_bubble3, pipe_freeze3},
          {27'd0, exp});
  endtask

  task automatic check1(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, pc_write1, if_id_write1, if_id_flush1, id_ex_bubble1, pipe_freeze1},
          {27'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_ex_memRead    = 1'b0;
    id_ex_rd         = 5'd0;
    if_id_rs1        = 5'd0;
    if_id_rs2        = 5'd0;
    if_id_uses_rs2   = 1'b0;
    branch_taken     = 1'b0;
    ex_mem_memAccess = 1'b0;
    dmem_ready       = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic set_lu_haz();
    id_ex_memRead = 1'b1;
    id_ex_rd      = 5'd5;
    if_id_rs1     = 5'd5;
    #1;
  endtask

  localparam logic [4:0] O_RUN    = 5'b11000;
  localparam logic [4:0] O_STALL  = 5'b00010;
  localparam logic [4:0] O_FLUSH  = 5'b11110;
  localparam logic [4:0] O_FREEZE = 5'b00001;
  localparam logic [4:0] O_RESET  = 5'b00110;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check3("reset_outputs", O_RESET);
    tick();
    check("reset_cnt1", stall_count1, 32'd0);
    check("reset_cnt3", stall_count3, 32'd0);
    rst_n = 1'b1;
    #1;
    check3("run_idle", O_RUN);

    // Single-cycle load-use bubble.
    set_lu_haz();
    check1("lu1_stall", O_STALL);
    tick();
    idle_inputs();
    #1;
    check1("lu1_release", O_RUN);
    check("lu1_cnt", stall_count1, 32'd1);

    // Three-cycle bubble; hazard inputs removed after detection.
    do_reset();
    set_lu_haz();
    check3("lu3_c1", O_STALL);
    tick();
    idle_inputs();
    #1;
    check3("lu3_c2", O_STALL);
    tick();
    check3("lu3_c3", O_STALL);
    tick();
    check3("lu3_done", O_RUN);
    check("lu3_cnt", stall_count3, 32'd3);

    id_ex_memRead = 1'b1;
    id_ex_rd      = 5'd0;
    if_id_rs1     = 5'd0;
    #1;
    check3("x0_no_stall", O_RUN);
    id_ex_rd       = 5'd7;
    if_id_rs1      = 5'd3;
    if_id_rs2      = 5'd7;
    if_id_uses_rs2 = 1'b0;
    #1;
    check3("rs2_unused", O_RUN);
    if_id_uses_rs2 = 1'b1;
    #1;
    check3("rs2_used", O_STALL);
    tick();
    idle_inputs();
    tick();
    tick();
    check3("rs2_done", O_RUN);
    check("rs2_cnt", stall_count3, 32'd6);

    // Branch on the second bubble cycle aborts the stall.
    do_reset();
    set_lu_haz();
    tick();
    idle_inputs();
    branch_taken = 1'b1;
    #1;
    check3("br_abort_flush", O_FLUSH);
    tick();
    branch_taken = 1'b0;
    #1;
    check3("br_abort_run", O_RUN);
    check("br_abort_cnt", stall_count3, 32'd1);

    // Four-cycle memory wait while lu_cnt=2, then two remaining bubbles.
    do_reset();
    set_lu_haz();
    tick();
    idle_inputs();
    ex_mem_memAccess = 1'b1;
    dmem_ready       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check3($sformatf("mw_freeze%0d", i), O_FREEZE);
      tick();
    end
    ex_mem_memAccess = 1'b0;
    dmem_ready       = 1'b1;
    #1;
    check3("mw_bubble1", O_STALL);
    tick();
    check3("mw_bubble2", O_STALL);
    tick();
    check3("mw_run", O_RUN);
    // One detection cycle before the freeze, plus 4 freeze and 2 bubble cycles.
    check("mw_cnt", stall_count3 - 32'd1, 32'd6);

    // Memory wait hides a branch for two cycles; flush on the release cycle.
    do_reset();
    ex_mem_memAccess = 1'b1;
    dmem_ready       = 1'b0;
    branch_taken     = 1'b1;
    #1;
    check3("mwbr_freeze0", O_FREEZE);
    tick();
    check3("mwbr_freeze1", O_FREEZE);
    tick();
    dmem_ready = 1'b1;
    #1;
    check3("mwbr_flush", O_FLUSH);
    tick();
    idle_inputs();
    #1;
    check3("mwbr_run", O_RUN);
    check("mwbr_cnt", stall_count3, 32'd2);

    // Build stall_count=7 while in LU_STALL, then reset mid-stall.
    set_lu_haz();
    tick();
    idle_inputs();
    tick();
    tick();
    check3("pre_rst_run", O_RUN);
    set_lu_haz();
    tick();
    idle_inputs();
    tick();
    check3("pre_rst_stall", O_STALL);
    check("pre_rst_cnt", stall_count3, 32'd7);
    rst_n = 1'b0;
    #1;
    check3("rst_forced0", O_RESET);
    tick();
    check("rst_cnt0", stall_count3, 32'd0);
    check3("rst_forced1", O_RESET);
    tick();
    check("rst_cnt_hold", stall_count3, 32'd0);
    rst_n = 1'b1;
    #1;
    check3("post_rst_run", O_RUN);
    tick();
    check("post_rst_cnt", stall_count3, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
